// File: rtl/led_flash_seq_pkg.sv
// Shared definitions for the LED pattern engine.
//   mode_e  : switch-selected display mode codes
//   dir_e   : sweep direction used by BOUNCE
//   LED_OFF : pin level that leaves an LED dark (LEDs are active low)
//   LED_ON  : pin level that lights an LED
package led_flash_seq_pkg;

    typedef enum logic [1:0] {
        MODE_DECODE = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic LED_OFF = 1'b1;
    localparam logic LED_ON  = 1'b0;

endpackage

// File: rtl/led_flash_seq_prescaler.sv
// Step-rate prescaler: produces one tick every STEP_DIV enabled cycles.
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset
//   i_en   : count enable; 0 holds the counter
//   i_clr  : synchronous clear, also suppresses the tick in that cycle
//   o_tick : combinational tick, high on the last count of each period
module led_prescaler #(
    parameter int STEP_DIV = 4,
    parameter int CNT_W    = 24
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == LP_LAST);
    assign o_tick = i_en & w_term & ~i_clr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_term ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_flash_seq.sv
// LED pattern engine: drives N_LED active-low LEDs from board switches in
// DECODE, RUN, BOUNCE and BLINK modes. led[N_LED-1] is position 0.
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset
//   i_sw   : position select from switches (asynchronous, synchronised here)
//   i_mode : mode select (asynchronous, synchronised here)
//   i_en   : run enable; 0 freezes the animation (DECODE keeps tracking)
//   o_led  : registered LED drive, 0 = lit
//   o_step : registered one-cycle pulse on every animation step
module led_flash_seq
    import led_flash_seq_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int SEL_W    = 3,
    parameter int STEP_DIV = 4,
    parameter int CNT_W    = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SEL_W-1:0] i_sw,
    input  logic [1:0]       i_mode,
    input  logic             i_en,
    output logic [N_LED-1:0] o_led,
    output logic             o_step
);

    localparam logic [SEL_W:0]   LP_N_EXT  = (SEL_W + 1)'(N_LED);
    localparam logic [SEL_W-1:0] LP_LAST   = SEL_W'(N_LED - 1);
    localparam logic [SEL_W-1:0] LP_PEN    = SEL_W'(N_LED - 2);
    localparam logic [N_LED-1:0] LP_ALLOFF = {N_LED{LED_OFF}};
    localparam logic [N_LED-1:0] LP_ALLON  = {N_LED{LED_ON}};

    // One dark-to-lit bit at the position; out-of-range positions light nothing.
    function automatic logic [N_LED-1:0] f_dec(input logic [SEL_W-1:0] p);
        logic [N_LED-1:0] v;
        v = LP_ALLOFF;
        for (int i = 0; i < N_LED; i++) begin
            if (int'(p) == N_LED - 1 - i) v[i] = LED_ON;
        end
        return v;
    endfunction

    logic [SEL_W-1:0] r_sw_m, r_sw_s;
    mode_e            r_mode_m, r_mode_s, r_mode_q;
    logic [SEL_W-1:0] r_pos;
    dir_e             r_dir;
    logic             r_phase;
    logic [N_LED-1:0] r_led;
    logic             r_step;

    logic             w_mode_chg;
    logic             w_tick;
    logic             w_sw_ok;
    logic [SEL_W-1:0] w_pos_nxt;
    dir_e             w_dir_nxt;
    logic             w_phase_nxt;
    logic [N_LED-1:0] w_led_nxt;

    assign w_mode_chg = (r_mode_s != r_mode_q);
    assign w_sw_ok    = ({1'b0, r_sw_s} < LP_N_EXT);

    // Clearing on a mode change realigns the step grid to the new pattern.
    led_prescaler #(
        .STEP_DIV (STEP_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_clr  (w_mode_chg),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sw_m   <= '0;
            r_sw_s   <= '0;
            r_mode_m <= MODE_DECODE;
            r_mode_s <= MODE_DECODE;
            r_mode_q <= MODE_DECODE;
            r_pos    <= '0;
            r_dir    <= DIR_UP;
            r_phase  <= 1'b0;
            r_led    <= LP_ALLOFF;
            r_step   <= 1'b0;
        end else begin
            r_sw_m   <= i_sw;
            r_sw_s   <= r_sw_m;
            r_mode_m <= mode_e'(i_mode);
            r_mode_s <= r_mode_m;
            r_mode_q <= r_mode_s;
            r_pos    <= w_pos_nxt;
            r_dir    <= w_dir_nxt;
            r_phase  <= w_phase_nxt;
            r_led    <= w_led_nxt;
            r_step   <= w_tick;
        end
    end

    // Without a tick everything holds, which is how i_en=0 freezes animations.
    always_comb begin
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_phase_nxt = r_phase;
        w_led_nxt   = r_led;
        if (w_mode_chg) begin
            w_pos_nxt   = w_sw_ok ? r_sw_s : '0;
            w_dir_nxt   = DIR_UP;
            w_phase_nxt = 1'b0;
            case (r_mode_s)
                MODE_DECODE: w_led_nxt = f_dec(r_sw_s);
                MODE_BLINK:  w_led_nxt = LP_ALLOFF;
                default:     w_led_nxt = f_dec(w_pos_nxt);
            endcase
        end else begin
            case (r_mode_s)
                MODE_DECODE: w_led_nxt = f_dec(r_sw_s);
                MODE_RUN: begin
                    if (w_tick) begin
                        w_pos_nxt = (r_pos == LP_LAST) ? '0 : r_pos + 1'b1;
                        w_led_nxt = f_dec(w_pos_nxt);
                    end
                end
                MODE_BOUNCE: begin
                    if (w_tick) begin
                        if (r_dir == DIR_UP) begin
                            if (r_pos == LP_LAST) begin
                                w_dir_nxt = DIR_DOWN;
                                w_pos_nxt = LP_PEN;
                            end else begin
                                w_pos_nxt = r_pos + 1'b1;
                            end
                        end else begin
                            if (r_pos == '0) begin
                                w_dir_nxt = DIR_UP;
                                w_pos_nxt = SEL_W'(1);
                            end else begin
                                w_pos_nxt = r_pos - 1'b1;
                            end
                        end
                        w_led_nxt = f_dec(w_pos_nxt);
                    end
                end
                default: begin
                    if (w_tick) begin
                        w_phase_nxt = ~r_phase;
                        w_led_nxt   = w_phase_nxt ? LP_ALLON : LP_ALLOFF;
                    end
                end
            endcase
        end
    end

    assign o_led  = r_led;
    assign o_step = r_step;

endmodule

// File: tb/tb_led_flash_seq.sv
module tb_led_flash_seq;

    logic       clk;
    logic       rst;
    logic [2:0] sw;
    logic [1:0] mode;
    logic       en;
    logic [7:0] led;
    logic       step;

    int n_assert = 0;
    int n_fail   = 0;

    led_flash_seq #(
        .N_LED    (8),
        .SEL_W    (3),
        .STEP_DIV (4),
        .CNT_W    (24)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_sw   (sw),
        .i_mode (mode),
        .i_en   (en),
        .o_led  (led),
        .o_step (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Active-low one-hot, position 0 on the MSB.
    function automatic logic [7:0] dec8(input int p);
        logic [7:0] m;
        m = 8'h80;
        return ~(m >> p);
    endfunction

    int bseq [13] = '{4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

    initial begin
        rst  = 1'b1;
        sw   = 3'd0;
        mode = 2'b00;
        en   = 1'b1;
        wait_neg(2);
        chk("reset_led", led, 8'hFF);
        chk("reset_step", {7'd0, step}, 8'h00);
        rst = 1'b0;

        // DECODE: three edges from switch to LED
        wait_neg(3);
        chk("dec_sw0", led, 8'h7F);
        sw = 3'd3;
        wait_neg(2);
        chk("dec_sw3_edge2", led, 8'h7F);
        wait_neg(1);
        chk("dec_sw3_edge3", led, 8'hEF);
        sw = 3'd7;
        wait_neg(3);
        chk("dec_sw7", led, 8'hFE);

        // RUN from position 6
        sw   = 3'd6;
        mode = 2'b01;
        wait_neg(3);
        chk("run_load_led", led, 8'hFD);
        chk("run_load_step", {7'd0, step}, 8'h00);
        wait_neg(3);
        chk("run_hold_led", led, 8'hFD);
        chk("run_hold_step", {7'd0, step}, 8'h00);
        wait_neg(1);
        chk("run_p7_led", led, 8'hFE);
        chk("run_p7_step", {7'd0, step}, 8'h01);
        wait_neg(1);
        chk("run_step_low", {7'd0, step}, 8'h00);
        wait_neg(3);
        chk("run_wrap_led", led, 8'h7F);
        chk("run_wrap_step", {7'd0, step}, 8'h01);

        // Asynchronous reset mid-RUN while step is high
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", led, 8'hFF);
        chk("async_rst_step", {7'd0, step}, 8'h00);
        wait_neg(1);
        rst = 1'b0;
        wait_neg(3);
        chk("post_rst_led", led, 8'hFD);

        // RUN->BOUNCE change landing on the would-be tick edge
        wait_neg(1);
        mode = 2'b10;
        sw   = 3'd2;
        wait_neg(2);
        chk("pre_chg_led", led, 8'hFD);
        wait_neg(1);
        chk("chg_led", led, dec8(2));
        chk("chg_no_step", {7'd0, step}, 8'h00);
        wait_neg(3);
        chk("chg_wait_step", {7'd0, step}, 8'h00);
        chk("chg_wait_led", led, dec8(2));
        wait_neg(1);
        chk("chg_next_led", led, dec8(3));
        chk("chg_next_step", {7'd0, step}, 8'h01);

        // BOUNCE through both ends
        foreach (bseq[i]) begin
            wait_neg(3);
            chk("bounce_gap_step", {7'd0, step}, 8'h00);
            wait_neg(1);
            chk($sformatf("bounce_led_%0d", i), led, dec8(bseq[i]));
            chk("bounce_step", {7'd0, step}, 8'h01);
        end

        // BLINK with an enable freeze
        mode = 2'b11;
        wait_neg(3);
        chk("blink_enter_led", led, 8'hFF);
        chk("blink_enter_step", {7'd0, step}, 8'h00);
        wait_neg(4);
        chk("blink_on_led", led, 8'h00);
        chk("blink_on_step", {7'd0, step}, 8'h01);
        wait_neg(2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_neg(1);
            chk("freeze_led", led, 8'h00);
            chk("freeze_step", {7'd0, step}, 8'h00);
        end
        en = 1'b1;
        wait_neg(1);
        chk("resume_hold_led", led, 8'h00);
        chk("resume_hold_step", {7'd0, step}, 8'h00);
        wait_neg(1);
        chk("resume_off_led", led, 8'hFF);
        chk("resume_off_step", {7'd0, step}, 8'h01);
        wait_neg(4);
        chk("blink_on2_led", led, 8'h00);
        chk("blink_on2_step", {7'd0, step}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
